pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It generalises the 4-bit lookahead carry unit to WIDTH bits, split into STAGES equal slices. Each slice is resolved in one clock using two-level 4-bit group lookahead, and the slice carry-out is registered into the next stage. A valid/ready handshake with full-pipeline stall is provided, along with add/sub mode and NZCV flags.

---
 rtl/cla_pkg.sv | 30 +++
 rtl/cla_block_4.sv | 27 ++
 rtl/pipelined_cla_adder.sv | 156 +++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Imported by the adder top and its 4-bit lookahead block.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  typedef struct packed {
    logic valid;
    logic cy;
  } stage_ctl_t;

  function automatic bit cla_legal(
    input int width,
    input int stages
  );
    bit ok_s;
    ok_s = (stages == 1) || (stages == 2) ||
           (stages == 4) || (stages == 8);
    return ok_s && (width > 0) &&
           ((width % (GROUP_W * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_block_4.sv
// 4-bit lookahead carry unit: per-bit carries plus
// group propagate/generate for the next lookahead level.
module cla_block_4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] p,
  input  logic [GROUP_W-1:0] g,
  input  logic               cin,
  output logic [GROUP_W-1:0] carry,
  output logic               p_out,
  output logic               g_out
);

  assign carry[0] = cin;
  assign carry[1] = g[0] | (p[0] & cin);
  assign carry[2] = g[1] | (p[1] & g[0]) |
                    (p[1] & p[0] & cin);
  assign carry[3] = g[2] | (p[2] & g[1]) |
                    (p[2] & p[1] & g[0]) |
                    (p[2] & p[1] & p[0] & cin);

  assign p_out = &p;
  assign g_out = g[3] | (p[3] & g[2]) |
                 (p[3] & p[2] & g[1]) |
                 (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder/subtractor, one lookahead slice per stage,
// slice carry registered between stages, full-pipeline stall.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP_W;

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  if (!cla_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_cla_adder: illegal WIDTH/STAGES");
  end

  logic             stall;
  logic [WIDTH-1:0] b_x;
  logic             cin0;
  logic [WIDTH-1:0] slice_sum;
  logic [STAGES-1:0] slice_co;
  logic             c_msb;
  stage_t           st_d [STAGES];
  stage_t           st_q [STAGES];
  flags_t           flags_d;
  flags_t           flags_q;

  assign stall    = st_q[STAGES-1].ctl.valid && !out_ready;
  assign in_ready = !stall;
  assign b_x      = b ^ {WIDTH{sub}};
  assign cin0     = sub | c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [SW-1:0] pv;
    logic [SW-1:0] gv;
    logic [SW-1:0] cv;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic          ci;

    if (k == 0) begin : g_src
      assign sa = a[SW-1:0];
      assign sb = b_x[SW-1:0];
      assign ci = cin0;
    end else begin : g_src
      assign sa = st_q[k-1].a[k*SW +: SW];
      assign sb = st_q[k-1].b[k*SW +: SW];
      assign ci = st_q[k-1].ctl.cy;
    end

    assign pv = sa ^ sb;
    assign gv = sa & sb;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_block_4 u_blk (
        .p    (pv[j*GROUP_W +: GROUP_W]),
        .g    (gv[j*GROUP_W +: GROUP_W]),
        .cin  (gc[j]),
        .carry(cv[j*GROUP_W +: GROUP_W]),
        .p_out(gp[j]),
        .g_out(gg[j])
      );
    end

    // Flat second level: gc[NG] is G_slice | (P_slice & ci)
    always_comb begin : lookahead
      logic term;
      term  = 1'b0;
      gc    = '0;
      gc[0] = ci;
      for (int j = 1; j <= NG; j++) begin
        term = ci;
        for (int i = 0; i < j; i++) term = term & gp[i];
        gc[j] = term;
        for (int i = 0; i < j; i++) begin
          term = gg[i];
          for (int m = i + 1; m < j; m++) term = term & gp[m];
          gc[j] = gc[j] | term;
        end
      end
    end

    assign slice_sum[k*SW +: SW] = pv ^ cv;
    assign slice_co[k] = gc[NG];

    if (k == STAGES - 1) begin : g_msb
      assign c_msb = cv[SW-1];
    end
  end

  always_comb begin
    st_d[0]           = '0;
    st_d[0].ctl.valid = in_valid;
    st_d[0].ctl.cy    = slice_co[0];
    st_d[0].a         = a;
    st_d[0].b         = b_x;
    st_d[0].sum[SW-1:0] = slice_sum[SW-1:0];
    for (int k = 1; k < STAGES; k++) begin
      st_d[k]        = st_q[k-1];
      st_d[k].ctl.cy = slice_co[k];
      st_d[k].sum[k*SW +: SW] = slice_sum[k*SW +: SW];
    end
  end

  always_comb begin
    flags_d   = '0;
    flags_d.c = slice_co[STAGES-1];
    flags_d.v = c_msb ^ slice_co[STAGES-1];
    flags_d.n = st_d[STAGES-1].sum[WIDTH-1];
    flags_d.z = (st_d[STAGES-1].sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      flags_q <= '0;
    end else if (!stall) begin
      st_q    <= st_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = st_q[STAGES-1].ctl.valid;
  assign sum       = st_q[STAGES-1].sum;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: random and directed
// beats, stall, mid-stream reset, and a STAGES/WIDTH sweep.
module tb_pipelined_cla_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         fc, fv, fn, fz;

  logic         sw_valid = 1'b0;
  logic [31:0]  sw_a = '0;
  logic [31:0]  sw_b = '0;
  logic         sw_ci = 1'b0;
  logic         sw_sub = 1'b0;
  logic         sw_ordy = 1'b1;
  logic [3:0]   sw_ir, sw_ov, sw_c, sw_v, sw_n, sw_z;
  logic [31:0]  sw_s1, sw_s2, sw_s8;
  logic [15:0]  sw_s16;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W+4:0] hold;

  typedef struct {
    logic [W+3:0] val;
    int           acc_edge;
    bit           chk_lat;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .flag_c(fc), .flag_v(fv),
    .flag_n(fn), .flag_z(fz)
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir[0]),
    .a(sw_a), .b(sw_b), .c_in(sw_ci), .sub(sw_sub),
    .out_valid(sw_ov[0]), .out_ready(sw_ordy),
    .sum(sw_s1), .flag_c(sw_c[0]), .flag_v(sw_v[0]),
    .flag_n(sw_n[0]), .flag_z(sw_z[0])
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir[1]),
    .a(sw_a), .b(sw_b), .c_in(sw_ci), .sub(sw_sub),
    .out_valid(sw_ov[1]), .out_ready(sw_ordy),
    .sum(sw_s2), .flag_c(sw_c[1]), .flag_v(sw_v[1]),
    .flag_n(sw_n[1]), .flag_z(sw_z[1])
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir[2]),
    .a(sw_a), .b(sw_b), .c_in(sw_ci), .sub(sw_sub),
    .out_valid(sw_ov[2]), .out_ready(sw_ordy),
    .sum(sw_s8), .flag_c(sw_c[2]), .flag_v(sw_v[2]),
    .flag_n(sw_n[2]), .flag_z(sw_z[2])
  );

  pipelined_cla_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir[3]),
    .a(sw_a[15:0]), .b(sw_b[15:0]), .c_in(sw_ci),
    .sub(sw_sub),
    .out_valid(sw_ov[3]), .out_ready(sw_ordy),
    .sum(sw_s16), .flag_c(sw_c[3]), .flag_v(sw_v[3]),
    .flag_n(sw_n[3]), .flag_z(sw_z[3])
  );

  // Plain-arithmetic reference: {sum, C, V, N, Z}
  function automatic logic [W+3:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic         s
  );
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic [W-1:0] r;
    logic         ce;
    logic         vv;
    yy   = s ? ~y : y;
    ce   = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ce};
    r    = full[W-1:0];
    vv   = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return {r, full[W], vv, r[W-1], (r == '0)};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h",
               nm, act, req);
    end
  endtask

  task automatic send(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic         s,
    input bit           lat,
    input bit           must_ready
  );
    int tries;
    bit done;
    tries = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = x; b = y; c_in = ci; sub = s;
      #1;
      if (must_ready)
        chk("in_ready_stream", 64'(in_ready), 64'd1);
      if (in_ready) begin
        exp_t e;
        e.val      = model(x, y, ci, s);
        e.acc_edge = cyc + 1;
        e.chk_lat  = lat;
        q.push_back(e);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 20) begin
          chk("accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic sweep();
    int acc;
    bit seen [4];
    int lat_req [4];
    logic [31:0] s;
    lat_req = '{1, 2, 8, 4};
    seen = '{0, 0, 0, 0};
    @(negedge clk);
    sw_valid = 1'b1;
    sw_a = '1; sw_b = '0; sw_ci = 1'b1; sw_sub = 1'b0;
    #1;
    chk("sweep_in_ready", 64'(sw_ir), 64'hF);
    acc = cyc + 1;
    @(posedge clk);
    #1 sw_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i] && !seen[i]) begin
          seen[i] = 1'b1;
          case (i)
            0: s = sw_s1;
            1: s = sw_s2;
            2: s = sw_s8;
            default: s = {16'h0, sw_s16};
          endcase
          chk($sformatf("sweep_lat_%0d", i),
              64'(cyc + 1 - acc), 64'(lat_req[i]));
          chk($sformatf("sweep_res_%0d", i),
              64'({s, sw_c[i], sw_v[i], sw_n[i], sw_z[i]}),
              64'({32'h0, 4'b1001}));
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (!seen[i])
        chk($sformatf("sweep_timeout_%0d", i), 64'd0, 64'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: actual sum 0x%0h required none",
                   sum);
        end else begin
          e = q.pop_front();
          chk("result", 64'({sum, fc, fv, fn, fz}), 64'(e.val));
          if (e.chk_lat)
            chk("latency", 64'(cyc + 1 - e.acc_edge), 64'(S));
        end
      end
    end
  end

  initial begin : stim
    #3;
    chk("reset_state",
        64'({in_ready, out_valid, sum, fc, fv, fn, fz}),
        64'({1'b1, 1'b0, {W{1'b0}}, 4'b0000}));
    chk("reset_sweep", 64'({sw_ov, sw_ir}), 64'h0F);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    send(32'h0, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 16; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1, 1'b1);
    drain();

    fork
      for (int i = 0; i < 10; i++)
        send($urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        #1;
        hold = {out_valid, sum, fc, fv, fn, fz};
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          #1;
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_frozen",
              64'({out_valid, sum, fc, fv, fn, fz}), 64'(hold));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++)
      send($urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async",
        64'({out_valid, in_ready, sum, fc, fv, fn, fz}),
        64'({1'b0, 1'b1, {W{1'b0}}, 4'b0000}));
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_idle", 64'(out_valid), 64'd0);
    end
    send($urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    sweep();
    drain();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
